// File: rtl/regfile_ctx_pkg.sv
// Shared types and constants for the register-file context save/restore sequencer.
package regfile_ctx_pkg;

    localparam int RF_FIRST   = 1;
    localparam int RF_LAST    = 31;
    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_RD,
        ST_SAVE_MEM,
        ST_REST_MEM,
        ST_REST_WR
    } state_t;

endpackage

// File: rtl/regfile_ctx_seq.sv
// Context save/restore sequencer: walks registers FIRST_REG..LAST_REG, copying
// each to a contiguous save area in memory or reloading it from there.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for save_start / restore_start
// SAVE_RD  | reading register idx from the register file
// SAVE_MEM | writing captured register value to memory, waiting for ack
// REST_MEM | reading save-area word from memory, waiting for ack
// REST_WR  | writing the fetched word into register idx
module regfile_ctx_seq
    import regfile_ctx_pkg::*;
#(
    parameter int FIRST_REG = RF_FIRST,
    parameter int LAST_REG  = RF_LAST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             save_start,
    input  logic             restore_start,
    input  logic [31:0]      base_addr,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] rf_rd_reg,
    input  logic [31:0]      rf_rd_data,
    output logic             rf_wr_en,
    output logic [IDX_W-1:0] rf_wr_reg,
    output logic [31:0]      rf_wr_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [31:0]      addr_base;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             done_q;
    logic             last;
    logic             start_any;
    logic             step;
    logic             finish;
    logic [31:0]      offset;

    assign last      = (idx == IDX_W'(LAST_REG));
    assign start_any = (state == ST_IDLE) && (save_start || restore_start);
    // Advance to the next register, or finish, after the last action on idx.
    assign step      = ((state == ST_SAVE_MEM) && mem_ack) || (state == ST_REST_WR);
    assign finish    = step && last;

    // Byte offset into the save area; wraps modulo 2^32 with the base.
    assign offset    = (32'(idx) - 32'(FIRST_REG)) * 32'(WORD_BYTES);

    // Next-state logic; mem_ack only matters in the two memory states.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (save_start)
                    state_nxt = ST_SAVE_RD;
                else if (restore_start)
                    state_nxt = ST_REST_MEM;
            end
            ST_SAVE_RD:  state_nxt = ST_SAVE_MEM;
            ST_SAVE_MEM: if (mem_ack) state_nxt = last ? ST_IDLE : ST_SAVE_RD;
            ST_REST_MEM: if (mem_ack) state_nxt = ST_REST_WR;
            ST_REST_WR:  state_nxt = last ? ST_IDLE : ST_REST_MEM;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Register index, captured save-area base and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            addr_base <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= finish;
            if (start_any) begin
                idx       <= IDX_W'(FIRST_REG);
                addr_base <= {base_addr[31:2], 2'b00};
            end else if (step && !last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Data capture: register value for a save, memory word for a restore.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == ST_SAVE_RD)
                wdata_q <= rf_rd_data;
            if ((state == ST_REST_MEM) && mem_ack)
                rdata_q <= mem_rdata;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign done       = done_q;
    assign mem_req    = (state == ST_SAVE_MEM) || (state == ST_REST_MEM);
    assign mem_we     = (state == ST_SAVE_MEM);
    assign mem_addr   = (state == ST_IDLE) ? 32'h0 : (addr_base + offset);
    assign mem_wdata  = wdata_q;
    assign rf_rd_reg  = idx;
    assign rf_wr_en   = (state == ST_REST_WR);
    assign rf_wr_reg  = idx;
    assign rf_wr_data = rdata_q;

endmodule

// File: tb/tb_regfile_ctx_seq.sv
// Self-checking bench for regfile_ctx_seq: behavioural register file and
// memory with configurable wait states, table-driven and random sequences.
module tb_regfile_ctx_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        save_start, restore_start;
    logic [31:0] base_addr;
    logic        busy, done;
    logic [4:0]  rf_rd_reg;
    logic [31:0] rf_rd_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_reg;
    logic [31:0] rf_wr_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    regfile_ctx_seq dut (
        .clk(clk), .rst(rst),
        .save_start(save_start), .restore_start(restore_start),
        .base_addr(base_addr), .busy(busy), .done(done),
        .rf_rd_reg(rf_rd_reg), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural register file and memory.
    logic [31:0] rf [32];
    logic [31:0] mem [logic [31:0]];
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_rec_t;
    wr_rec_t wlog [$];
    int rd_cnt, rfw_cnt, wcnt;
    int waits;
    bit inject, hold;
    logic [31:0] hold_addr;

    assign rf_rd_data = rf[rf_rd_reg];

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Memory responder with 'waits' wait states, plus register-file write port.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wcnt >= waits && !(hold && mem_addr == hold_addr)) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wlog.push_back('{addr: mem_addr, data: mem_wdata});
                    end else begin
                        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                        rd_cnt++;
                    end
                end else begin
                    wcnt++;
                end
            end else if (inject && $urandom_range(0, 1) == 1) begin
                mem_ack = 1'b1;
            end
            if (rf_wr_en) begin
                rf[rf_wr_reg] = rf_wr_data;
                rfw_cnt++;
            end
        end
    end

    typedef struct {
        bit          sv;
        bit          rs;
        logic [31:0] base;
        int          w;
        bit          inj;
        logic [31:0] pat;
    } vec_t;

    function automatic logic [31:0] exp_addr(logic [31:0] base, int r);
        return (base & 32'hFFFF_FFFC) + 32'(4 * (r - 1));
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int  done_cyc;
        bit  is_save;
        is_save = v.sv;
        wlog.delete(); mem.delete();
        rd_cnt = 0; rfw_cnt = 0;
        rf[0] = 32'h0;
        for (int r = 1; r < 32; r++) begin
            if (is_save) rf[r] = v.pat + 32'(r);
            else begin
                rf[r] = ~(v.pat + 32'(r));
                mem[exp_addr(v.base, r)] = v.pat + 32'(r);
            end
        end
        waits = v.w; inject = v.inj;
        @(negedge clk);
        save_start = v.sv; restore_start = v.rs; base_addr = v.base;
        @(posedge clk); #1;
        save_start = 1'b0; restore_start = 1'b0; base_addr = $urandom;
        done_cyc = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, " busy_after_start"}, 128'(busy), 128'(1));
            restore_start = (v.inj && k == 10);
            if (done) begin
                done_cyc = k;
                check({tag, " busy_in_done"}, 128'(busy), 128'(0));
                break;
            end
        end
        restore_start = 1'b0;
        inject = 1'b0;
        @(negedge clk);
        check({tag, " done_one_cycle"}, 128'(done), 128'(0));
        check({tag, " done_cycle"}, 128'(done_cyc), 128'(1 + 31 * (2 + v.w)));
        if (is_save) begin
            check({tag, " save_writes"}, 128'(wlog.size()), 128'(31));
            check({tag, " save_reads"}, 128'(rd_cnt), 128'(0));
            check({tag, " save_rf_wr"}, 128'(rfw_cnt), 128'(0));
            for (int r = 1; r < 32; r++) begin
                if (r - 1 < wlog.size()) begin
                    check($sformatf("%s addr_r%0d", tag, r), 128'(wlog[r-1].addr), 128'(exp_addr(v.base, r)));
                    check($sformatf("%s data_r%0d", tag, r), 128'(wlog[r-1].data), 128'(v.pat + 32'(r)));
                end
            end
        end else begin
            check({tag, " rest_reads"}, 128'(rd_cnt), 128'(31));
            check({tag, " rest_mem_writes"}, 128'(wlog.size()), 128'(0));
            check({tag, " rest_r0"}, 128'(rf[0]), 128'(0));
            for (int r = 1; r < 32; r++)
                check($sformatf("%s rf_r%0d", tag, r), 128'(rf[r]), 128'(v.pat + 32'(r)));
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({busy, done, mem_req, mem_we, rf_wr_en, rf_rd_reg, rf_wr_reg,
                     mem_addr, mem_wdata, rf_wr_data});
    endfunction

    vec_t vecs [6];

    initial begin
        bit found;
        vecs[0] = '{sv: 1, rs: 0, base: 32'h0000_1000, w: 0, inj: 0, pat: 32'hA500_0000};
        vecs[1] = '{sv: 0, rs: 1, base: 32'h0000_3000, w: 2, inj: 0, pat: 32'h5A00_0000};
        vecs[2] = '{sv: 1, rs: 1, base: 32'h0000_2003, w: 0, inj: 0, pat: 32'h1234_0000};
        vecs[3] = '{sv: 1, rs: 0, base: 32'h0000_4000, w: 1, inj: 1, pat: 32'hC0DE_0000};
        vecs[4] = '{sv: 1, rs: 0, base: 32'hFFFF_FFF8, w: 0, inj: 0, pat: 32'h7700_0000};
        vecs[5] = '{sv: 0, rs: 1, base: 32'hFFFF_FFF2, w: 1, inj: 0, pat: 32'h3300_0000};

        rst = 1'b1; save_start = 1'b0; restore_start = 1'b0; base_addr = 32'h0;
        waits = 0; inject = 1'b0; hold = 1'b0; hold_addr = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        for (int r = 0; r < 32; r++) rf[r] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", all_outs(), 128'(0));

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while SAVE_MEM r10 waits for an ack that never comes.
        hold = 1'b1; hold_addr = 32'h0000_1024; waits = 0; wlog.delete();
        for (int r = 1; r < 32; r++) rf[r] = 32'hA500_0000 + 32'(r);
        @(negedge clk);
        save_start = 1'b1; base_addr = 32'h0000_1000;
        @(posedge clk); #1;
        save_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_req && mem_addr == hold_addr) begin found = 1'b1; break; end
        end
        check("rst_reach_r10", 128'(found), 128'(1));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async_outputs", all_outs(), 128'(0));
        check("rst_partial_writes", 128'(wlog.size()), 128'(9));
        hold = 1'b0;
        @(negedge clk); rst = 1'b0;
        found = 1'b0;
        repeat (4) begin @(negedge clk); if (done) found = 1'b1; end
        check("rst_no_done", 128'(found), 128'(0));
        run_vec(vecs[0], "after_rst");

        // Randomized sequences against the reference model.
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v.sv   = $urandom_range(0, 1);
            v.rs   = !v.sv;
            v.base = $urandom;
            v.w    = $urandom_range(0, 2);
            v.inj  = $urandom_range(0, 1);
            v.pat  = $urandom;
            run_vec(v, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_ctx_seq.md
# regfile_ctx_seq

Context save/restore sequencer for the 32-entry, 32-bit CPU register file. On command it walks registers 1..31, either copying each one to a contiguous save area in data memory or reloading each one from it. It uses one register-file read port, the register-file write port and a req/ack data-memory port. The CPU pipeline is held off while `busy` is high; interrupt entry/exit and task switch use this block.

## Interface
Parameters:
- `FIRST_REG`, 1: first register saved/restored. r0 is hard-wired zero and is never touched.
- `LAST_REG`, 31: last register saved/restored.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `save_start`  in  1  request a save sequence; sampled only while `busy`=0.
- `restore_start`  in  1  request a restore sequence; sampled only while `busy`=0.
- `base_addr`  in  32  byte address of the save area; sampled with the start.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `rf_rd_reg`  out  5  register-file read address.
- `rf_rd_data`  in  32  register-file read data; valid by the end of the cycle in which `rf_rd_reg` is driven (the register file samples on negedge).
- `rf_wr_en`  out  1  register-file write enable.
- `rf_wr_reg`  out  5  register-file write address.
- `rf_wr_data`  out  32  register-file write data.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  32  word-aligned byte address.
- `mem_wdata`  out  32  memory write data.
- `mem_ack`  in  1  memory completion; single cycle.
- `mem_rdata`  in  32  read data; valid in the `mem_ack` cycle.

## Operation
- States:
  - IDLE
  - SAVE_RD
  - SAVE_MEM
  - REST_MEM
  - REST_WR
- IDLE behaviour:
  - `save_start` → SAVE_RD.
  - `restore_start` → REST_MEM.
  - Both high: save wins and restore is dropped.
  - Starts while `busy`=1 are ignored and not queued.
- On start:
  - `idx` ← `FIRST_REG`.
  - `addr_base` ← {`base_addr`[31:2], 2'b00}.
- Address rule: `mem_addr` = `addr_base` + 4·(`idx`−`FIRST_REG`), 32-bit wrap-around with no error.
- SAVE_RD:
  - `rf_rd_reg`=`idx`.
  - At the end of the cycle, capture `rf_rd_data` into the `mem_wdata` register.
  - → SAVE_MEM.
- SAVE_MEM:
  - `mem_req`=1, `mem_we`=1.
  - Address and data are held stable until `mem_ack`.
  - On ack: if `idx`=`LAST_REG` → IDLE with `done`; otherwise `idx`+1 → SAVE_RD.
- REST_MEM:
  - `mem_req`=1, `mem_we`=0.
  - On ack, capture `mem_rdata` into the `rf_wr_data` register → REST_WR.
- REST_WR:
  - `rf_wr_en`=1, `rf_wr_reg`=`idx`, for one cycle.
  - If `idx`=`LAST_REG` → IDLE with `done`; otherwise `idx`+1 → REST_MEM.
- `mem_ack` is ignored when `mem_req`=0.
- `mem_req` drops in the cycle after the ack.
- `rf_wr_en` is never asserted during a save. `mem_req` is never asserted in SAVE_RD or REST_WR.

## Timing
- Reset values, with IDLE: all outputs 0. This covers `busy`, `done`, `mem_req`, `mem_we`, `rf_wr_en`, all address and data outputs, and `idx`.
- Reset mid-sequence returns to IDLE immediately:
  - no `done` pulse;
  - a pending `mem_req` is withdrawn;
  - the partial save area or register contents are left as-is.
- `busy` is registered: high from the cycle after start is sampled until the final ack/write cycle inclusive.
- `done` is registered, high exactly the one cycle after the last ack (save) or the last `REST_WR` (restore). `busy`=0 in that cycle, and a new start is accepted in it.
- Save latency with zero-wait memory (ack in the first req cycle):
  - start sampled at edge 0;
  - SAVE_RD r1 in cycle 1, SAVE_MEM r1 in cycle 2, …, SAVE_MEM r31 in cycle 62;
  - `done` in cycle 63.
  - Each memory wait state adds 1 cycle.
- Restore latency with zero-wait memory: REST_MEM r1 in cycle 1, REST_WR r1 in cycle 2, …, REST_WR r31 in cycle 62; `done` in cycle 63.
- Register-file write commit is the register file's own latency. The CPU must not read restored registers until `done`.

## Structure
- Shared package `regfile_ctx_pkg` holds:
  - the state enum (5 states);
  - `RF_FIRST`=1, `RF_LAST`=31, `WORD_BYTES`=4;
  - the register index width 5.
- Single module. The index counter and address adder stay inline, and no sub-module is warranted.

## Test plan
- Save, zero-wait: preload rN = 32'hA500_0000+N, `base_addr`=32'h0000_1000, pulse `save_start` → 31 writes with addr 32'h1000+4(N−1) and data A500_00NN; `done` in cycle 63; `rf_wr_en` never 1.
- Restore, 2 wait states per access: memory word k = 32'h5A00_0000+k+1 → r1..r31 written with matching values; `done` in cycle 31·4+1=125; r0 untouched.
- Simultaneous `save_start`+`restore_start`, `base_addr`=32'h2003 → save runs, first `mem_addr`=32'h2000, restore never runs.
- `restore_start` pulsed mid-save and `mem_ack` pulsed while `mem_req`=0 → both ignored; sequence and counts unchanged.
- `rst` asserted during SAVE_MEM at r10 with no ack → all outputs 0 asynchronously, no `done`; a following save restarts at r1 and completes normally.
- `base_addr`=32'hFFFF_FFF8 → r3 at address 32'h0000_0000 (wrap); completes with `done`.
